dyn_disp_scan: RTL

Time-multiplexed 6-digit common-anode 7-segment driver for the 24h clock. It is the reader/decoder end of the counter BCD outputs: it consumes the hour digits (QH/QL) plus the minute and second digit pairs and drives one digit at a time. It snapshots the digits once per frame so the display never tears, blanks between digits to stop ghosting, and supports per-field blinking for time-set mode.

---
 rtl/clock_pkg.sv | 22 ++
 rtl/bcd_to_seg7.sv | 15 +
 rtl/dyn_disp_scan.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared constants for the 24h clock display path: slot order and
// active-low 7-segment patterns {g,f,e,d,c,b,a}.
package clock_pkg;

  typedef enum logic [2:0] {
    SLOT_SL = 3'd0,
    SLOT_SH = 3'd1,
    SLOT_ML = 3'd2,
    SLOT_MH = 3'd3,
    SLOT_HL = 3'd4,
    SLOT_HH = 3'd5
  } slot_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal
// codes render as a dash.
module bcd_to_seg7
  import clock_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/dyn_disp_scan.sv
// Six-digit multiplexed common-anode display scanner with per-frame digit
// snapshot, inter-digit blanking, field blinking and leading-zero suppression.
module dyn_disp_scan
  import clock_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 8,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] HQH,
  input  logic [3:0] HQL,
  input  logic [2:0] MQH,
  input  logic [3:0] MQL,
  input  logic [2:0] SQH,
  input  logic [3:0] SQL,
  input  logic [2:0] BLINK,
  input  logic       LZ_SUP,
  input  logic       COLON,
  output logic [5:0] AN,
  output logic [6:0] SEG,
  output logic       DP
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] pc;
  slot_e         slot;
  logic          tick;
  logic          frame_end;

  logic [1:0] snap_hh;
  logic [3:0] snap_hl;
  logic [2:0] snap_mh;
  logic [3:0] snap_ml;
  logic [2:0] snap_sh;
  logic [3:0] snap_sl;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic [3:0] digit;
  logic [3:0] digit_max;
  logic       blink_en;
  logic [6:0] dec_seg;
  logic       blanked;
  logic [5:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;

  assign tick      = (pc == PW'(SCAN_DIV - 1));
  assign frame_end = tick && (slot == SLOT_HH);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc   <= '0;
      slot <= SLOT_SL;
    end else if (tick) begin
      pc   <= '0;
      slot <= (slot == SLOT_HH) ? SLOT_SL : slot_e'(slot + 3'd1);
    end else begin
      pc <= pc + PW'(1);
    end
  end

  // Loading on the last tick of a frame keeps all six digits coherent.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      snap_hh <= '0;
      snap_hl <= '0;
      snap_mh <= '0;
      snap_ml <= '0;
      snap_sh <= '0;
      snap_sl <= '0;
    end else if (frame_end) begin
      snap_hh <= HQH;
      snap_hl <= HQL;
      snap_mh <= MQH;
      snap_ml <= MQL;
      snap_sh <= SQH;
      snap_sl <= SQL;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    digit     = 4'd0;
    digit_max = 4'd9;
    blink_en  = 1'b0;
    case (slot)
      SLOT_SL: begin digit = snap_sl;          digit_max = 4'd9; blink_en = BLINK[0]; end
      SLOT_SH: begin digit = {1'b0, snap_sh};  digit_max = 4'd5; blink_en = BLINK[0]; end
      SLOT_ML: begin digit = snap_ml;          digit_max = 4'd9; blink_en = BLINK[1]; end
      SLOT_MH: begin digit = {1'b0, snap_mh};  digit_max = 4'd5; blink_en = BLINK[1]; end
      SLOT_HL: begin digit = snap_hl;          digit_max = 4'd9; blink_en = BLINK[2]; end
      SLOT_HH: begin digit = {2'b00, snap_hh}; digit_max = 4'd2; blink_en = BLINK[2]; end
      default: ;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (digit),
    .seg (dec_seg)
  );

  // Blanking keeps the anode on but wins over both the digit and the dash.
  always_comb begin
    blanked = (blink_en && blink_phase) ||
              ((slot == SLOT_HH) && LZ_SUP && (snap_hh == 2'd0));
    an_nxt  = ~(6'd1 << slot);
    seg_nxt = (digit > digit_max) ? SEG_DASH : dec_seg;
    dp_nxt  = 1'b1;
    if (blanked) begin
      seg_nxt = SEG_BLANK;
    end else if (COLON && ((slot == SLOT_ML) || (slot == SLOT_HL))) begin
      dp_nxt = 1'b0;
    end
    if (pc < PW'(BLANK_CYC)) begin
      an_nxt  = 6'h3F;
      seg_nxt = SEG_BLANK;
      dp_nxt  = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      AN  <= 6'h3F;
      SEG <= SEG_BLANK;
      DP  <= 1'b1;
    end else begin
      AN  <= an_nxt;
      SEG <= seg_nxt;
      DP  <= dp_nxt;
    end
  end

endmodule
